line_loader: RTL and testbench
==============================

# line_loader

Fetch engine that fills the 63-entry line buffer with one image row. On `start` it streams the row's pixels out of the synchronous image ROM, one read per cycle, and writes each returned byte into the line buffer at its column index, then pulses `done`. It sits directly upstream of the line buffer; the line buffer's `index`/`val_in`/`write_signal` pins connect to this block's `lb_index`/`lb_val`/`lb_wr`.

## Interface
- `LINE_LEN`, 63: pixels per line; 1..64; columns 0..LINE_LEN-1.
- `IMG_W`, 64: ROM row pitch in pixels; must be ≥ LINE_LEN.
- `IMG_H`, 64: number of valid image rows.
- `AW`, 12: ROM address width; must be ≥ log2(IMG_W*IMG_H).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: one-cycle request to load a row; sampled only in IDLE.
- `row` in 6: row to load; captured with `start`.
- `stall` in 1: when 1, no new ROM read is issued this cycle.
- `rom_rd` out 1: ROM read strobe.
- `rom_addr` out AW: `row*IMG_W + col`, valid while `rom_rd`=1.
- `rom_q` in 8: ROM data, valid the cycle after `rom_rd`.
- `lb_index` out 6: line buffer column for the write.
- `lb_val` out 8: line buffer write data.
- `lb_wr` out 1: line buffer write strobe.
- `busy` out 1: 1 from the cycle after start acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse after the last write.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On `start`=1, capture `row` into `row_q`, clear `col`, and go to FETCH.
  - `start` in any other state is ignored.
- FETCH:
  - Each cycle with `stall`=0: `rom_rd`=1, `rom_addr`=`row_q*IMG_W+col`, then `col` increments.
  - Each cycle with `stall`=1: `rom_rd`=0 and `col` holds.
  - After the read of column LINE_LEN-1 issues, go to DRAIN.
- Write path:
  - `lb_wr` is `rom_rd` registered by one cycle.
  - `lb_index` is the issuing `col`, registered by one cycle.
  - `lb_val` = `rom_q` combinationally while `lb_wr`=1; otherwise 0.
  - A write already in flight completes regardless of `stall`.
- DRAIN: lasts one cycle and carries the final `lb_wr`; then go to DONE.
- DONE: `done`=1 for one cycle; then go to IDLE.
- Address arithmetic is unsigned and truncated to AW bits. `col` is 6 bits and never exceeds LINE_LEN-1.
- Outputs at reset: `rom_rd`=0, `rom_addr`=0, `lb_wr`=0, `lb_index`=0, `lb_val`=0, `busy`=0, `done`=0. State=IDLE, `col`=0, `row_q`=0.
- Reset asserted mid-load: outputs drop immediately and no `done` is produced. Line buffer contents already written are left as they are.
- Rows with `row` ≥ IMG_H: see Configuration.

## Timing
- `start` sampled high at edge E0 with `stall` held 0:
  - `busy`=1 from E0 through E0+LINE_LEN+2.
  - `rom_rd` high in cycles 1..LINE_LEN (col 0..LINE_LEN-1).
  - `lb_wr` high in cycles 2..LINE_LEN+1.
  - `done` high in cycle LINE_LEN+2 (cycle 65 for the default).
  - IDLE again in cycle LINE_LEN+3.
- Each `stall` cycle during FETCH adds exactly one cycle to the sequence.
- Stall in the cycle after the last read: no effect (the FSM is already in DRAIN).
- Throughput: one pixel per cycle. A new `start` can be accepted in the first IDLE cycle after `done`.

## Configuration
- `LL_ZERO_EDGE_EN` defined, for `row` ≥ IMG_H:
  - No ROM reads: `rom_rd` stays 0.
  - Timing and `lb_wr`/`lb_index` sequence are identical to a normal load, with `lb_val`=0 on every write (zero-padding for the edge).
- `LL_ZERO_EDGE_EN` undefined:
  - `row` ≥ IMG_H is clamped to IMG_H-1 at capture and a normal ROM load is performed.
  - Rows < IMG_H behave identically in both builds.

## Test plan
- Reset:
  - Hold `rst`=0 with `start`=1 → all outputs 0 and no `rom_rd`.
  - Release, then pulse `start` with `row`=0 → `rom_rd` in cycles 1..63 with `rom_addr` 0..62.
- Normal load:
  - ROM model holds `rom_q` = (addr & 0xFF); `row`=3.
  - Expect 63 writes at `lb_index` 0..62 with `lb_val` 192..254 (addresses 192..254).
  - Expect `done` exactly once in cycle 65.
- Stall:
  - Load `row`=1 with `stall`=1 during cycles 5–7.
  - Expect no duplicate or missing index and every write value correct.
  - Expect `done` in cycle 68.
- Ignored start: `start` pulsed in cycle 30 of a load → no restart, `row_q` unchanged, single `done`.
- Reset mid-load: `rst`=0 in cycle 20 → `lb_wr`, `busy` and `rom_rd` go to 0 immediately; no `done`; next `start` loads normally.
- Out-of-range row, `row`=63 with IMG_H=40:
  - With `LL_ZERO_EDGE_EN`: 63 writes of 0 and no `rom_rd`.
  - Without it: reads from addresses 39*64+0..62.

Source files
------------

// File: rtl/line_loader.sv
// Row fetch engine: streams one image row from a synchronous ROM into the line buffer, one pixel per cycle.
// Optional LL_ZERO_EDGE_EN: out-of-range rows produce zero-valued writes instead of being clamped.
module line_loader #(
    parameter int LINE_LEN = 63,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int AW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    row,
    input  logic          stall,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_q,
    output logic [5:0]    lb_index,
    output logic [7:0]    lb_val,
    output logic          lb_wr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [5:0] LAST_COL = 6'(LINE_LEN - 1);
`ifndef LL_ZERO_EDGE_EN
    localparam logic [5:0] MAX_ROW  = 6'(IMG_H - 1);
`endif

    state_t      r_state;
    logic [5:0]  r_row_q;
    logic [5:0]  r_col;
    logic [5:0]  r_lb_index;
    logic        r_lb_wr;
`ifdef LL_ZERO_EDGE_EN
    logic        r_zero;
`endif

    logic          w_issue;
    logic          w_row_oob;
    logic          w_last;
    logic          w_pad;
    logic [AW-1:0] w_addr;

    assign w_issue   = (r_state == FETCH) && !stall;
    assign w_row_oob = {26'd0, row} >= 32'(IMG_H);
    assign w_last    = (r_col == LAST_COL);
    assign w_addr    = AW'(r_row_q) * AW'(IMG_W) + AW'(r_col);

`ifdef LL_ZERO_EDGE_EN
    assign w_pad = r_zero;
`else
    assign w_pad = 1'b0;
`endif

    // The write slot tracks issue slots even for padded rows, so timing is identical.
    assign rom_rd   = w_issue && !w_pad;
    assign rom_addr = rom_rd ? w_addr : '0;
    assign lb_wr    = r_lb_wr;
    assign lb_index = r_lb_index;
    assign lb_val   = (r_lb_wr && !w_pad) ? rom_q : 8'd0;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_row_q    <= '0;
            r_col      <= '0;
            r_lb_index <= '0;
            r_lb_wr    <= 1'b0;
`ifdef LL_ZERO_EDGE_EN
            r_zero     <= 1'b0;
`endif
        end else begin
            r_lb_wr <= w_issue;
            if (w_issue) begin
                r_lb_index <= r_col;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_col   <= '0;
                        r_state <= FETCH;
`ifdef LL_ZERO_EDGE_EN
                        r_row_q <= row;
                        r_zero  <= w_row_oob;
`else
                        r_row_q <= w_row_oob ? MAX_ROW : row;
`endif
                    end
                end
                FETCH: begin
                    if (!stall) begin
                        if (w_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end
                DRAIN:   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_loader.sv
// Scoreboard bench for line_loader: stimulus queues expected ROM reads, writes and done cycles;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_line_loader;
    localparam int LINE_LEN = 63;
    localparam int IMG_W    = 64;
    localparam int IMG_H    = 40;
    localparam int AW       = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [5:0]    row = '0;
    logic          stall = 1'b0;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q = '0;
    logic [5:0]    lb_index;
    logic [7:0]    lb_val;
    logic          lb_wr;
    logic          busy;
    logic          done;

    line_loader #(.LINE_LEN(LINE_LEN), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .row(row), .stall(stall),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
        .lb_index(lb_index), .lb_val(lb_val), .lb_wr(lb_wr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ROM content: low byte of the address folded with its upper nibble.
    function automatic logic [7:0] rom_fn(input int a);
        logic [11:0] av;
        av = a[11:0];
        return av[7:0] ^ {av[11:8], av[11:8]};
    endfunction

    always @(posedge clk) if (rom_rd) rom_q <= rom_fn(int'(rom_addr));

    typedef struct {int idx; int val;} wr_t;
    int  exp_rd[$];
    wr_t exp_wr[$];
    int  exp_done[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: output asserted with nothing expected (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (rom_rd) begin
                if (exp_rd.size() == 0) unexpected("rom_rd");
                else check("rom_addr", int'(rom_addr), exp_rd.pop_front());
            end
            if (lb_wr) begin
                if (exp_wr.size() == 0) unexpected("lb_wr");
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("lb_index", int'(lb_index), w.idx);
                    check("lb_val", int'(lb_val), w.val);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) unexpected("done");
                else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                    check("busy_at_done", int'(busy), 1);
                end
            end
        end
    end

    // mode: 0 no stall, 1 stall in cycles 5..7, 2 random stalls. ign: cycle of an ignored start (0 = none).
    task automatic do_load(input int r, input int mode, input int ign);
        int er;
        bit pad;
        int e0;
        int issued;
        int k;
        int last_k;
        pad = 1'b0;
        er  = r;
        if (r >= IMG_H) begin
`ifdef LL_ZERO_EDGE_EN
            pad = 1'b1;
`else
            er = IMG_H - 1;
`endif
        end
        for (int c = 0; c < LINE_LEN; c++) begin
            wr_t w;
            w.idx = c;
            w.val = pad ? 0 : int'(rom_fn(er * IMG_W + c));
            exp_wr.push_back(w);
            if (!pad) exp_rd.push_back(er * IMG_W + c);
        end
        @(posedge clk); #1;
        start = 1'b1;
        row   = r[5:0];
        e0    = cyc;
        issued = 0;
        k = 0;
        last_k = 0;
        while (issued < LINE_LEN && k < 400) begin
            @(posedge clk); #1;
            k++;
            start = (k == ign);
            if (k == ign) row = 6'($urandom_range(63));
            case (mode)
                1:       stall = (k >= 5 && k <= 7);
                2:       stall = (k < 300) && ($urandom_range(3) == 0);
                default: stall = 1'b0;
            endcase
            if (!stall) issued++;
            if (issued == LINE_LEN) last_k = k;
        end
        exp_done.push_back(e0 + last_k + 2);
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'($urandom_range(1));
        @(posedge clk); #1;
        stall = 1'b0;
        @(posedge clk); #1;
        check("busy_after_done", int'(busy), 0);
        @(posedge clk); #1;
        check("reads_left", exp_rd.size(), 0);
        check("writes_left", exp_wr.size(), 0);
        check("done_left", exp_done.size(), 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        $display("[TB] load row %0d mode %0d: start cycle %0d, last read cycle %0d", r, mode, e0, last_k);
    endtask

    initial begin
        int dones;
        rst   = 1'b0;
        start = 1'b1;
        row   = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_rom_rd", int'(rom_rd), 0);
            check("rst_outputs", int'({rom_addr, lb_index, lb_val, lb_wr, busy, done}), 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        mon_en = 1'b1;

        do_load(0, 0, 0);
        do_load(3, 0, 0);
        do_load(1, 1, 0);
        do_load(7, 0, 30);

        // Reset in cycle 20 of a load: everything drops at once and no done follows.
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        row   = 6'd5;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_rom_rd", int'(rom_rd), 0);
        check("midrst_lb_wr", int'(lb_wr), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("done_after_rst", dones, 0);
        mon_en = 1'b1;
        $display("[TB] reset mid-load checked");

        do_load(12, 0, 0);
        do_load(63, 0, 0);
        do_load(45, 1, 0);
        for (int i = 0; i < 6; i++) begin
            do_load(int'($urandom_range(63)), 2, (i % 2 == 0) ? int'($urandom_range(40) + 1) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
